sram_bus_bridge: RTL and testbench
==================================

Name: sram_bus_bridge

Overview:
Parametrised successor to the current AVR/SRAM bus path. It owns the external SRAM control pins and time-shares the SRAM between two masters: the AVR (serially loaded address, optional auto-increment, strobed read/write with configurable wait states) and the SNES (read-only pass-through). It sits at system level between the AVR port, the SNES cartridge bus and the SRAM. Tristate pads stay at top level; this block supplies the output-enable.

Parameters:
ADDR_W, 21, SRAM/SNES address width in bits.
DATA_W, 8, data width in bits.
WAIT_CYCLES, 2, number of cycles the SRAM strobe is held low per AVR access (legal values >= 1).

Ports:
clk  in  1  system clock, all logic on the rising edge.
reset_n  in  1  synchronous, active-low reset.
snes_mode  in  1  1 = SNES owns the SRAM, 0 = AVR owns it.
si  in  1  serial address input, shifted in MSB first.
sreg_en_n  in  1  low = shift si into the address register this clock.
counter_n  in  1  low = increment the address register after each completed AVR access.
avr_we_n  in  1  AVR write request (a falling edge starts an access).
avr_oe_n  in  1  AVR read request (a falling edge starts an access).
avr_wdata  in  DATA_W  AVR write data, sampled in SETUP.
avr_rdata  out  DATA_W  registered read data.
busy  out  1  AVR access in progress.
snes_addr  in  ADDR_W  SNES address.
snes_rdata  out  DATA_W  SNES read data.
sram_addr  out  ADDR_W  SRAM address.
sram_wdata  out  DATA_W  SRAM write data.
sram_rdata  in  DATA_W  SRAM read data (from pad).
sram_data_oe  out  1  1 = drive the SRAM data pads.
sram_ce_n  out  1  SRAM chip enable.
sram_oe_n  out  1  SRAM output enable.
sram_we_n  out  1  SRAM write enable.
debug  out  8  status (see Optional Feature).

Behaviour:
- Reset (reset_n low at a clk edge), values at the next edge:
  - FSM goes to IDLE.
  - addr_reg = 0; avr_rdata = 0; sram_wdata = 0; busy = 0.
  - sram_ce_n, sram_oe_n and sram_we_n all = 1; sram_data_oe = 0.
  - Edge-detect registers = 1. Overrun flag cleared.
  - Reset wins over all other inputs. Reset in the middle of an access aborts it with no address increment.
- Edge detection: the previous values of avr_we_n and avr_oe_n are registered. A request is a 1->0 transition seen in IDLE. If both fall in the same cycle, the write wins.
- Address shift: in IDLE with sreg_en_n = 0, addr_reg <= {addr_reg[ADDR_W-2:0], si}. Shifting is ignored in every other state.
- If a shift and a request occur in the same cycle, the request starts and the shift is ignored.
- FSM states: IDLE, SETUP, STROBE, HOLD, SNES.
  - IDLE -> SNES when snes_mode = 1; this has priority over a request in the same cycle.
  - IDLE -> SETUP on a request. The direction is latched.
  - SETUP, 1 cycle:
    - sram_addr = addr_reg, sram_ce_n = 0, busy = 1.
    - For a write: sram_wdata <= avr_wdata and sram_data_oe = 1.
  - STROBE, exactly WAIT_CYCLES cycles, counted by an internal counter:
    - sram_we_n = 0 (write) or sram_oe_n = 0 (read).
    - For a read, avr_rdata <= sram_rdata on the last STROBE cycle.
  - HOLD, 1 cycle:
    - Strobes = 1; ce_n, address and write data are held.
    - If counter_n = 0, addr_reg <= addr_reg + 1, wrapping from 2^ADDR_W-1 to 0.
    - Next state is IDLE; busy drops on entry to IDLE.
  - AVR access latency: request edge to busy low is WAIT_CYCLES + 3 cycles.
  - SNES state:
    - sram_addr = snes_addr (combinational), sram_ce_n = 0, sram_oe_n = 0, sram_we_n = 1, sram_data_oe = 0.
    - snes_rdata = sram_rdata (combinational).
    - Returns to IDLE the cycle after snes_mode = 0.
- Outside the SNES state, snes_rdata = all ones.
- snes_mode rising during an AVR access: the access completes first, then the FSM goes to SNES.
- A request edge in SETUP, STROBE, HOLD or SNES is dropped and sets the sticky overrun flag.
- In IDLE: sram_addr = addr_reg and all strobes are high.

Optional Feature:
Macro SRAM_BUS_BRIDGE_DEBUG_EN.
- Defined:
  - debug[2:0] = state encoding (IDLE=0, SETUP=1, STROBE=2, HOLD=3, SNES=4).
  - debug[5:3] = low 3 bits of the wait counter.
  - debug[6] = busy.
  - debug[7] = sticky overrun flag, cleared only by reset.
- Undefined: debug = 0, and the overrun flag logic is not built.

Test Plan:
- Reset: reset_n low 2 cycles during STROBE -> next edge: ce_n = oe_n = we_n = 1, data_oe = 0, busy = 0, addr_reg = 0, avr_rdata = 0.
- Shift 21 bits of 0x1ABCDE, then write 0x5A (WAIT_CYCLES = 2):
  - sram_addr = 0x1ABCDE, sram_wdata = 0x5A.
  - we_n low exactly 2 cycles, busy high 4 cycles.
  - counter_n = 1, so addr_reg is unchanged.
- addr_reg = 0x1FFFFF, counter_n = 0, read with sram_rdata = 0xC3 -> avr_rdata = 0xC3 after the last STROBE cycle; addr_reg wraps to 0x000000.
- Raise snes_mode during STROBE of a write:
  - The write completes.
  - In SNES: snes_addr = 0x000123 gives sram_addr = 0x000123, oe_n = 0; sram_rdata = 0x77 gives snes_rdata = 0x77.
  - Drop snes_mode -> IDLE next cycle, snes_rdata = 0xFF.
- avr_we_n and avr_oe_n fall together -> write performed.
- A second avr_oe_n edge during HOLD is dropped; debug[7] = 1 with the macro, debug = 0 without it.

Source files
------------

// File: rtl/sram_bus_bridge_if.sv
// Bundles the AVR, SNES and SRAM pin groups that pass through sram_bus_bridge.
//   slave  : the bridge's side. It drives busy, read data, the SRAM pins and debug.
//   master : the system or testbench side. It drives AVR and SNES requests and the SRAM read data.
// Signals:
//   snes_mode, si, sreg_en_n, counter_n, avr_we_n, avr_oe_n, avr_wdata -> bridge
//   avr_rdata, busy                                                    <- bridge
//   snes_addr -> bridge; snes_rdata <- bridge
//   sram_addr, sram_wdata, sram_data_oe, sram_ce_n/oe_n/we_n <- bridge; sram_rdata -> bridge
//   debug <- bridge (8-bit status)
interface sram_bus_bridge_if #(
  parameter int unsigned ADDR_W = 21,
  parameter int unsigned DATA_W = 8
);
  logic              snes_mode;
  logic              si;
  logic              sreg_en_n;
  logic              counter_n;
  logic              avr_we_n;
  logic              avr_oe_n;
  logic [DATA_W-1:0] avr_wdata;
  logic [DATA_W-1:0] avr_rdata;
  logic              busy;
  logic [ADDR_W-1:0] snes_addr;
  logic [DATA_W-1:0] snes_rdata;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  logic              sram_data_oe;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [7:0]        debug;

  modport slave (
    input  snes_mode, si, sreg_en_n, counter_n, avr_we_n, avr_oe_n, avr_wdata,
    input  snes_addr, sram_rdata,
    output avr_rdata, busy, snes_rdata, sram_addr, sram_wdata, sram_data_oe,
    output sram_ce_n, sram_oe_n, sram_we_n, debug
  );

  modport master (
    output snes_mode, si, sreg_en_n, counter_n, avr_we_n, avr_oe_n, avr_wdata,
    output snes_addr, sram_rdata,
    input  avr_rdata, busy, snes_rdata, sram_addr, sram_wdata, sram_data_oe,
    input  sram_ce_n, sram_oe_n, sram_we_n, debug
  );
endinterface

// File: rtl/sram_bus_bridge.sv
// sram_bus_bridge: owns the external SRAM control pins and time-shares the SRAM between two masters.
//   - AVR: loads a serial address, can auto-increment it, and issues strobed reads and writes.
//   - SNES: read-only pass-through.
// Ports:
//   clk     : system clock; all logic runs on the rising edge.
//   reset_n : synchronous, active-low reset.
//   bus     : sram_bus_bridge_if.slave, carrying the AVR, SNES and SRAM signal groups.
// Parameters:
//   ADDR_W      : address width.
//   DATA_W      : data width.
//   WAIT_CYCLES : number of cycles the strobe is held low. It must be >= 1.
// Optional build macro SRAM_BUS_BRIDGE_DEBUG_EN:
//   - Defined: debug = {overrun, busy, wait_cnt[2:0], state}.
//   - Undefined: debug = 0 and no overrun flag is built.
module sram_bus_bridge #(
  parameter int unsigned ADDR_W      = 21,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic              clk,
  input logic              reset_n,
  sram_bus_bridge_if.slave bus
);

  // The counter is at least 3 bits wide so that debug can always show its low 3 bits.
  localparam int unsigned CntW = ($clog2(WAIT_CYCLES + 1) > 3) ? $clog2(WAIT_CYCLES + 1) : 3;
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSetup  = 3'd1,
    StStrobe = 3'd2,
    StHold   = 3'd3,
    StSnes   = 3'd4
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CntW-1:0]   cnt_q;
  logic              is_write_q;
  logic              we_prev_q, oe_prev_q;
  logic [DATA_W-1:0] rdata_q, wdata_q;
  logic              busy_q, data_oe_q, ce_n_q, oe_n_q, we_n_q;

  logic we_fall, oe_fall, req;
  assign we_fall = we_prev_q & ~bus.avr_we_n;
  assign oe_fall = oe_prev_q & ~bus.avr_oe_n;
  assign req     = we_fall | oe_fall;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      we_prev_q  <= 1'b1;
      oe_prev_q  <= 1'b1;
      rdata_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      data_oe_q  <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
    end else begin
      we_prev_q <= bus.avr_we_n;
      oe_prev_q <= bus.avr_oe_n;
      case (state_q)
        StIdle: begin
          if (bus.snes_mode) begin
            state_q <= StSnes;
            ce_n_q  <= 1'b0;
            oe_n_q  <= 1'b0;
          end else if (req) begin
            // A write wins when both requests fall together. A request also beats a shift.
            state_q    <= StSetup;
            is_write_q <= we_fall;
            busy_q     <= 1'b1;
            ce_n_q     <= 1'b0;
            if (we_fall) begin
              wdata_q   <= bus.avr_wdata;
              data_oe_q <= 1'b1;
            end
          end else if (!bus.sreg_en_n) begin
            addr_q <= {addr_q[ADDR_W-2:0], bus.si};
          end
        end
        StSetup: begin
          state_q <= StStrobe;
          cnt_q   <= '0;
          if (is_write_q) we_n_q <= 1'b0;
          else            oe_n_q <= 1'b0;
        end
        StStrobe: begin
          if (cnt_q == CntLast) begin
            state_q <= StHold;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            if (!is_write_q) rdata_q <= bus.sram_rdata;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StHold: begin
          state_q   <= StIdle;
          busy_q    <= 1'b0;
          ce_n_q    <= 1'b1;
          data_oe_q <= 1'b0;
          if (!bus.counter_n) addr_q <= addr_q + ADDR_W'(1);
        end
        StSnes: begin
          if (!bus.snes_mode) begin
            state_q <= StIdle;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.sram_addr    = (state_q == StSnes) ? bus.snes_addr : addr_q;
  assign bus.snes_rdata   = (state_q == StSnes) ? bus.sram_rdata : '1;
  assign bus.avr_rdata    = rdata_q;
  assign bus.busy         = busy_q;
  assign bus.sram_wdata   = wdata_q;
  assign bus.sram_data_oe = data_oe_q;
  assign bus.sram_ce_n    = ce_n_q;
  assign bus.sram_oe_n    = oe_n_q;
  assign bus.sram_we_n    = we_n_q;

`ifdef SRAM_BUS_BRIDGE_DEBUG_EN
  // Sticky flag: a request edge arrived while the bridge could not accept it.
  logic overrun_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overrun_q <= 1'b0;
    end else if (state_q != StIdle && req) begin
      overrun_q <= 1'b1;
    end
  end
  assign bus.debug = {overrun_q, busy_q, cnt_q[2:0], state_q};
`else
  assign bus.debug = '0;
`endif

endmodule

// File: tb/tb_sram_bus_bridge.sv
module tb_sram_bus_bridge;
  localparam int unsigned AW = 21;
  localparam int unsigned DW = 8;
  localparam int unsigned WAITC = 2;
  localparam int ASPACE = 1 << AW;

  logic clk;
  logic reset_n;
  int checks = 0;
  int errors = 0;

  sram_bus_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_bus_bridge #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WAITC)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.snes_mode = 0; bus.si = 0; bus.sreg_en_n = 1; bus.counter_n = 1;
    bus.avr_we_n = 1; bus.avr_oe_n = 1; bus.avr_wdata = '0;
    bus.snes_addr = '0; bus.sram_rdata = '0;
  endtask

  task automatic shift_addr(input logic [AW-1:0] a);
    bus.sreg_en_n = 0;
    for (int i = AW - 1; i >= 0; i--) begin
      bus.si = a[i];
      tick();
    end
    bus.sreg_en_n = 1;
  endtask

  // Drives one AVR access and measures what the SRAM pins did. The SRAM model drives rv only while
  // oe_n is low, so sampling read data on the wrong cycle returns ~rv.
  task automatic run_access(input bit wr, input bit rd, input logic [DW-1:0] d,
      input logic [DW-1:0] rv, input bit inc, input int snes_at,
      output int busy_cyc, output int we_cyc, output int oe_cyc,
      output logic [AW-1:0] st_addr, output logic [DW-1:0] st_wdata,
      output bit pin_bad, output bit timeout);
    busy_cyc = 0; we_cyc = 0; oe_cyc = 0; st_addr = 'x; st_wdata = 'x;
    pin_bad = 0; timeout = 1;
    bus.counter_n = !inc; bus.avr_wdata = d; bus.sram_rdata = ~rv;
    if (wr) bus.avr_we_n = 0;
    if (rd) bus.avr_oe_n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == snes_at) bus.snes_mode = 1;
      if (bus.busy) busy_cyc++;
      if (!bus.sram_we_n) begin
        we_cyc++; st_addr = bus.sram_addr; st_wdata = bus.sram_wdata;
        if (!bus.sram_data_oe || bus.sram_ce_n) pin_bad = 1;
      end
      if (!bus.sram_oe_n) begin
        oe_cyc++; st_addr = bus.sram_addr;
        if (bus.sram_data_oe || bus.sram_ce_n) pin_bad = 1;
      end
      bus.sram_rdata = bus.sram_oe_n ? ~rv : rv;
      if (!bus.busy && busy_cyc > 0) begin
        timeout = 0;
        break;
      end
    end
    bus.avr_we_n = 1; bus.avr_oe_n = 1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0; tick(); tick(); reset_n = 1; tick();
    checks++; if (bus.sram_ce_n !== 1'b1 || bus.sram_oe_n !== 1'b1 || bus.sram_we_n !== 1'b1)
      begin errors++; $display("FAIL reset_strobes got ce%b oe%b we%b exp 111", bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n); end
    checks++; if (bus.sram_data_oe !== 1'b0 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL reset_oe_busy got %b%b exp 00", bus.sram_data_oe, bus.busy); end
    checks++; if (bus.sram_addr !== '0 || bus.avr_rdata !== '0)
      begin errors++; $display("FAIL reset_addr_rdata got %h %h exp 0 0", bus.sram_addr, bus.avr_rdata); end
    checks++; if (bus.snes_rdata !== 8'hFF || bus.debug !== 8'h00)
      begin errors++; $display("FAIL reset_snes_debug got %h %h exp ff 00", bus.snes_rdata, bus.debug); end
    // Reset during STROBE of a read: the read is aborted with no data capture and no increment.
    shift_addr(21'h000155);
    bus.counter_n = 0; bus.sram_rdata = 8'hAA; bus.avr_oe_n = 0;
    tick(); tick();
    checks++; if (bus.sram_oe_n !== 1'b0 || bus.busy !== 1'b1)
      begin errors++; $display("FAIL midreset_strobe got oe%b busy%b exp 0 1", bus.sram_oe_n, bus.busy); end
    reset_n = 0; tick();
    checks++; if ({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_data_oe, bus.busy} !== 5'b11100)
      begin errors++; $display("FAIL midreset_pins got %b exp 11100", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_data_oe, bus.busy}); end
    checks++; if (bus.sram_addr !== '0 || bus.avr_rdata !== '0)
      begin errors++; $display("FAIL midreset_addr got %h %h exp 0 0", bus.sram_addr, bus.avr_rdata); end
    tick(); bus.avr_oe_n = 1; bus.counter_n = 1; reset_n = 1; tick(); tick();
    checks++; if (bus.sram_addr !== '0 || bus.avr_rdata !== '0 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL postreset got %h %h %b exp 0 0 0", bus.sram_addr, bus.avr_rdata, bus.busy); end
  endtask

  task automatic test_write_basic();
    int bc, wc, oc; logic [AW-1:0] sa; logic [DW-1:0] sw; bit bad, to;
    shift_addr(21'h1ABCDE);
    checks++; if (bus.sram_addr !== 21'h1ABCDE)
      begin errors++; $display("FAIL shift_addr got %h exp 1abcde", bus.sram_addr); end
    run_access(1, 0, 8'h5A, 8'h00, 0, -1, bc, wc, oc, sa, sw, bad, to);
    checks++; if (to || bc !== WAITC + 2)
      begin errors++; $display("FAIL wr_busy got %0d to%0d exp %0d", bc, to, WAITC + 2); end
    checks++; if (wc !== WAITC || oc !== 0)
      begin errors++; $display("FAIL wr_strobes got we%0d oe%0d exp %0d 0", wc, oc, WAITC); end
    checks++; if (sa !== 21'h1ABCDE || sw !== 8'h5A || bad)
      begin errors++; $display("FAIL wr_pins got %h %h bad%0d exp 1abcde 5a", sa, sw, bad); end
    checks++; if (bus.sram_addr !== 21'h1ABCDE)
      begin errors++; $display("FAIL wr_noinc got %h exp 1abcde", bus.sram_addr); end
  endtask

  task automatic test_read_wrap();
    int bc, wc, oc; logic [AW-1:0] sa; logic [DW-1:0] sw; bit bad, to;
    shift_addr(21'h1FFFFF);
    run_access(0, 1, 8'h00, 8'hC3, 1, -1, bc, wc, oc, sa, sw, bad, to);
    checks++; if (to || bc !== WAITC + 2 || oc !== WAITC || wc !== 0)
      begin errors++; $display("FAIL rd_timing got busy%0d oe%0d we%0d exp %0d %0d 0", bc, oc, wc, WAITC + 2, WAITC); end
    checks++; if (bus.avr_rdata !== 8'hC3 || sa !== 21'h1FFFFF || bad)
      begin errors++; $display("FAIL rd_data got %h addr %h exp c3 1fffff", bus.avr_rdata, sa); end
    checks++; if (bus.sram_addr !== 21'h000000)
      begin errors++; $display("FAIL rd_wrap got %h exp 000000", bus.sram_addr); end
  endtask

  task automatic test_snes();
    int bc, wc, oc; logic [AW-1:0] sa; logic [DW-1:0] sw; bit bad, to;
    shift_addr(21'h0F0F0F);
    run_access(1, 0, 8'h3C, 8'h00, 0, 1, bc, wc, oc, sa, sw, bad, to);
    checks++; if (to || bc !== WAITC + 2 || wc !== WAITC || sw !== 8'h3C)
      begin errors++; $display("FAIL snes_wr_completes got busy%0d we%0d data %h exp %0d %0d 3c", bc, wc, sw, WAITC + 2, WAITC); end
    bus.snes_addr = 21'h000123; bus.sram_rdata = 8'h77; #1;
    checks++; if (bus.sram_addr !== 21'h000123 || bus.snes_rdata !== 8'h77)
      begin errors++; $display("FAIL snes_pass got %h %h exp 000123 77", bus.sram_addr, bus.snes_rdata); end
    checks++; if ({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_data_oe} !== 4'b0010)
      begin errors++; $display("FAIL snes_pins got %b exp 0010", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_data_oe}); end
    bus.snes_mode = 0; tick();
    checks++; if (bus.snes_rdata !== 8'hFF || bus.sram_oe_n !== 1'b1 || bus.sram_addr !== 21'h0F0F0F)
      begin errors++; $display("FAIL snes_exit got %h oe%b %h exp ff 1 0f0f0f", bus.snes_rdata, bus.sram_oe_n, bus.sram_addr); end
  endtask

  task automatic test_both_fall();
    int bc, wc, oc; logic [AW-1:0] sa; logic [DW-1:0] sw; bit bad, to;
    shift_addr(21'h0ABCD0);
    run_access(1, 1, 8'hE1, 8'h00, 1, -1, bc, wc, oc, sa, sw, bad, to);
    checks++; if (to || wc !== WAITC || oc !== 0 || sw !== 8'hE1 || sa !== 21'h0ABCD0)
      begin errors++; $display("FAIL both_fall got we%0d oe%0d %h %h exp %0d 0 e1 0abcd0", wc, oc, sw, sa, WAITC); end
    checks++; if (bus.sram_addr !== 21'h0ABCD1)
      begin errors++; $display("FAIL both_fall_inc got %h exp 0abcd1", bus.sram_addr); end
  endtask

  // Random back-to-back accesses checked against a simple address/data model.
  task automatic test_random();
    int bc, wc, oc; logic [AW-1:0] sa; logic [DW-1:0] sw; bit bad, to;
    int maddr; logic [DW-1:0] mrdata;
    mrdata = bus.avr_rdata === 8'hC3 ? 8'hC3 : 8'hXX;
    maddr = 0;
    for (int n = 0; n < 24; n++) begin
      bit wr, inc; logic [DW-1:0] d, rv;
      wr = 1'($urandom); inc = 1'($urandom);
      d = 8'($urandom); rv = 8'($urandom);
      if (n == 0 || $urandom_range(0, 2) == 0) begin
        maddr = ($urandom_range(0, 3) == 0) ? ASPACE - 1 : int'($urandom_range(0, ASPACE - 1));
        shift_addr(AW'(maddr));
      end
      run_access(wr, !wr, d, rv, inc, -1, bc, wc, oc, sa, sw, bad, to);
      if (!wr) mrdata = rv;
      checks++; if (to || bc !== WAITC + 2)
        begin errors++; $display("FAIL rnd%0d_busy got %0d exp %0d", n, bc, WAITC + 2); end
      checks++; if (wc !== (wr ? WAITC : 0) || oc !== (wr ? 0 : WAITC) || bad)
        begin errors++; $display("FAIL rnd%0d_strobe got we%0d oe%0d bad%0d wr%0d", n, wc, oc, bad, wr); end
      checks++; if (sa !== AW'(maddr) || (wr && sw !== d))
        begin errors++; $display("FAIL rnd%0d_pins got %h %h exp %h %h", n, sa, sw, AW'(maddr), d); end
      if (inc) maddr = (maddr + 1) % ASPACE;
      checks++; if (bus.sram_addr !== AW'(maddr))
        begin errors++; $display("FAIL rnd%0d_addr got %h exp %h", n, bus.sram_addr, AW'(maddr)); end
      if (n > 0 || !wr) begin
        checks++; if (bus.avr_rdata !== mrdata)
          begin errors++; $display("FAIL rnd%0d_rdata got %h exp %h", n, bus.avr_rdata, mrdata); end
      end
    end
  endtask

  task automatic test_overrun();
    bus.counter_n = 1; bus.avr_oe_n = 0;
    tick(); bus.avr_oe_n = 1;
    tick(); tick(); tick();
    checks++; if (bus.busy !== 1'b1 || bus.sram_oe_n !== 1'b1)
      begin errors++; $display("FAIL ovr_hold got busy%b oe%b exp 1 1", bus.busy, bus.sram_oe_n); end
    bus.avr_oe_n = 0;
    tick(); tick(); tick();
    checks++; if (bus.busy !== 1'b0 || bus.sram_oe_n !== 1'b1 || bus.sram_ce_n !== 1'b1)
      begin errors++; $display("FAIL ovr_dropped got busy%b oe%b ce%b exp 0 1 1", bus.busy, bus.sram_oe_n, bus.sram_ce_n); end
    bus.avr_oe_n = 1; tick();
`ifdef SRAM_BUS_BRIDGE_DEBUG_EN
    checks++; if (bus.debug[7] !== 1'b1 || bus.debug[6] !== 1'b0 || bus.debug[2:0] !== 3'd0)
      begin errors++; $display("FAIL ovr_debug got %b exp 1_0_xxx_000", bus.debug); end
`else
    checks++; if (bus.debug !== 8'h00)
      begin errors++; $display("FAIL ovr_debug got %h exp 00", bus.debug); end
`endif
  endtask

  initial begin
    reset_n = 0;
    test_reset();
    test_write_basic();
    test_read_wrap();
    test_snes();
    test_both_fall();
    test_random();
    test_overrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
